// File: rtl/test_status_mmio.sv
// Memory-mapped tohost result responder: latches PASS/FAIL/TIMEOUT, drives status/LEDs, offers read-back.
// Optional watchdog built only when TEST_STATUS_WATCHDOG_EN is defined.
module test_status_mmio #(
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned BLINK_LOG2     = 22
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        wen,
  output logic [31:0] rdata,
  output logic        sel,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [30:0] fail_num,
  output logic [5:0]  leds
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_PASS    = 2'd1;
  localparam logic [1:0] ST_FAIL    = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  localparam logic [29:0] TOHOST_W = TOHOST_ADDR[31:2];
  localparam logic [29:0] STATUS_W = TOHOST_ADDR[31:2] + 30'd1;
  localparam logic [29:0] CYCLE_W  = TOHOST_ADDR[31:2] + 30'd2;

`ifdef TEST_STATUS_WATCHDOG_EN
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);
`endif

  logic [1:0]            state_q, state_d;
  logic [31:0]           cycle_q, cycle_d;
  logic [30:0]           fail_num_q, fail_num_d;
  logic [BLINK_LOG2-1:0] blink_cnt_q, blink_cnt_d;
  logic                  blink_tgl_q, blink_tgl_d;

  logic hit_tohost, hit_status, hit_cycle;
  logic result_wr;
  logic blink;

  assign hit_tohost = (addr[31:2] == TOHOST_W);
  assign hit_status = (addr[31:2] == STATUS_W);
  assign hit_cycle  = (addr[31:2] == CYCLE_W);
  assign sel        = hit_tohost | hit_status | hit_cycle;

  assign result_wr = (state_q == ST_RUN) && wen && hit_tohost && wdata[0];

  always_comb begin
    state_d     = state_q;
    cycle_d     = cycle_q;
    fail_num_d  = fail_num_q;
    blink_cnt_d = blink_cnt_q + BLINK_LOG2'(1);
    // Blink phase flips on counter wrap, giving a half-period of 2^BLINK_LOG2 cycles.
    blink_tgl_d = blink_tgl_q ^ (&blink_cnt_q);
    if (state_q == ST_RUN) begin
`ifdef TEST_STATUS_WATCHDOG_EN
      cycle_d = cycle_q + 32'd1;
`else
      cycle_d = (&cycle_q) ? cycle_q : cycle_q + 32'd1;
`endif
      if (result_wr) begin
        if (wdata == 32'd1) begin
          state_d = ST_PASS;
        end else begin
          state_d    = ST_FAIL;
          fail_num_d = wdata[31:1];
        end
      end
`ifdef TEST_STATUS_WATCHDOG_EN
      // A result write in the expiry cycle takes precedence over the watchdog.
      else if (cycle_q == WD_LAST) begin
        state_d = ST_TIMEOUT;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      cycle_q     <= '0;
      fail_num_q  <= '0;
      blink_cnt_q <= '0;
      blink_tgl_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cycle_q     <= cycle_d;
      fail_num_q  <= fail_num_d;
      blink_cnt_q <= blink_cnt_d;
      blink_tgl_q <= blink_tgl_d;
    end
  end

  assign done     = (state_q != ST_RUN);
  assign pass     = (state_q == ST_PASS);
  assign fail     = (state_q == ST_FAIL) || (state_q == ST_TIMEOUT);
  assign fail_num = (state_q == ST_FAIL) ? fail_num_q : '0;
  assign blink    = ~blink_tgl_q;

  always_comb begin
    leds = 6'b000001;
    case (state_q)
      ST_RUN:     leds = {5'b00000, blink};
      ST_PASS:    leds = 6'b111111;
      ST_FAIL:    leds = {blink, fail_num[4:0]};
      ST_TIMEOUT: leds = blink ? 6'b101010 : 6'b010101;
      default:    leds = 6'b000001;
    endcase
  end

  always_comb begin
    rdata = '0;
    if (hit_status) begin
      rdata = {fail_num[29:0], state_q};
    end else if (hit_cycle) begin
      rdata = cycle_q;
    end
  end

endmodule

// File: tb/tb_test_status_mmio.sv
// Directed bench for test_status_mmio; watchdog cases follow TEST_STATUS_WATCHDOG_EN.
module tb_test_status_mmio;

  localparam logic [31:0] A_TOHOST = 32'h0000_1000;
  localparam logic [31:0] A_STATUS = 32'h0000_1004;
  localparam logic [31:0] A_CYCLE  = 32'h0000_1008;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wen;
  logic [31:0] rdata;
  logic        sel;
  logic        done;
  logic        pass;
  logic        fail;
  logic [30:0] fail_num;
  logic [5:0]  leds;

  int unsigned checks = 0;
  int unsigned errors = 0;

  test_status_mmio #(
    .TOHOST_ADDR   (32'h0000_1000),
    .TIMEOUT_CYCLES(1000),
    .BLINK_LOG2    (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .wdata   (wdata),
    .wen     (wen),
    .rdata   (rdata),
    .sel     (sel),
    .done    (done),
    .pass    (pass),
    .fail    (fail),
    .fail_num(fail_num),
    .leds    (leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wen = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wen   = 1'b1;
    step();
    wen   = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  initial begin
    rst   = 1'b1;
    addr  = '0;
    wdata = '0;
    wen   = 1'b0;
    step();
    do_reset();

    // reset state
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_fail", fail, 1'b0);
    check("rst_fail_num", fail_num, 31'd0);
    check("rst_leds", leds, 6'b000001);
    rd("rst_status", A_STATUS, 32'h0);
    rd("rst_cycle", A_CYCLE, 32'h0);
    check("rst_sel_cycle", sel, 1'b1);
    addr = 32'h0000_2000;
    #1;
    check("sel_miss", sel, 1'b0);
    check("rdata_miss", rdata, 32'h0);

    // blink: bit0 toggles at edge 4 with BLINK_LOG2=2
    step_n(3);
    check("blink_e3", leds, 6'b000001);
    step();
    check("blink_e4", leds, 6'b000000);
    step();
    rd("cycle_5", A_CYCLE, 32'd5);

    // PASS written at cycle 5
    wr(A_TOHOST, 32'h1);
    check("pass_pass", pass, 1'b1);
    check("pass_done", done, 1'b1);
    check("pass_fail", fail, 1'b0);
    check("pass_leds", leds, 6'b111111);
    rd("pass_status", A_STATUS, 32'h1);
    rd("pass_cycle", A_CYCLE, 32'd6);
    step_n(3);
    rd("pass_cycle_frozen", A_CYCLE, 32'd6);

    // ignored writes keep RUN
    do_reset();
    addr = A_TOHOST; #1;
    check("sel_tohost", sel, 1'b1);
    check("rdata_tohost", rdata, 32'h0);
    wr(A_TOHOST, 32'h0);
    wr(A_TOHOST, 32'h4);
    addr = A_STATUS; #1;
    check("sel_status", sel, 1'b1);
    wr(A_STATUS, 32'h1);
    addr = 32'h0000_100A; #1;
    check("sel_cycle_offs", sel, 1'b1);
    wr(32'h0000_100A, 32'hABCD_0001);
    check("ign_done", done, 1'b0);
    rd("ign_status", A_STATUS, 32'h0);
    rd("ign_cycle", A_CYCLE, 32'd4);

    // FAIL with number 3, sticky afterwards
    wr(32'h0000_1003, 32'h7);
    check("fail_fail", fail, 1'b1);
    check("fail_done", done, 1'b1);
    check("fail_pass", pass, 1'b0);
    check("fail_num3", fail_num, 31'd3);
    check("fail_leds_lo", leds[4:0], 5'b00011);
    rd("fail_status", A_STATUS, 32'hE);
    wr(A_TOHOST, 32'h1);
    check("fail_sticky_pass", pass, 1'b0);
    rd("fail_sticky_status", A_STATUS, 32'hE);

    // reset mid-FAIL with a write presented during reset
    rst   = 1'b1;
    addr  = A_TOHOST;
    wdata = 32'h1;
    wen   = 1'b1;
    step();
    rst = 1'b0;
    wen = 1'b0;
    check("rst2_done", done, 1'b0);
    check("rst2_fail", fail, 1'b0);
    check("rst2_fail_num", fail_num, 31'd0);
    check("rst2_leds", leds, 6'b000001);
    rd("rst2_status", A_STATUS, 32'h0);
    rd("rst2_cycle", A_CYCLE, 32'h0);
    wr(A_TOHOST, 32'h1);
    check("rst2_then_pass", pass, 1'b1);

    // largest failure number
    do_reset();
    wr(A_TOHOST, 32'hFFFF_FFFF);
    check("maxfail_num", fail_num, 31'h7FFF_FFFF);
    check("maxfail_leds_lo", leds[4:0], 5'b11111);
    rd("maxfail_status", A_STATUS, 32'hFFFF_FFFE);

`ifdef TEST_STATUS_WATCHDOG_EN
    do_reset();
    step_n(999);
    check("wd_e999_fail", fail, 1'b0);
    rd("wd_e999_status", A_STATUS, 32'h0);
    step();
    check("wd_fail", fail, 1'b1);
    check("wd_done", done, 1'b1);
    check("wd_pass", pass, 1'b0);
    rd("wd_status", A_STATUS, 32'h3);
    rd("wd_cycle", A_CYCLE, 32'd1000);
    check("wd_leds", (leds == 6'b101010) || (leds == 6'b010101), 1'b1);

    do_reset();
    step_n(999);
    wr(A_TOHOST, 32'h1);
    check("wd_race_pass", pass, 1'b1);
    rd("wd_race_status", A_STATUS, 32'h1);
    rd("wd_race_cycle", A_CYCLE, 32'd1000);
`else
    do_reset();
    step_n(2000);
    check("nowd_done", done, 1'b0);
    rd("nowd_status", A_STATUS, 32'h0);
    rd("nowd_cycle", A_CYCLE, 32'd2000);
    wr(A_TOHOST, 32'h1);
    check("nowd_late_pass", pass, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/test_status_mmio.md
# test_status_mmio

Memory-mapped test-result responder on the core's data-memory bus. Software running on the core writes a RISC-V `tohost`-style result word to it. The block latches pass, fail or timeout, exposes the result on status outputs and the board LEDs, and offers read-back registers. It lets rv32ui tests report their own outcome on silicon, where no testbench is watching the program counter.

## Interface
- `TOHOST_ADDR`, default `32'h0000_1000`, word-aligned base address; the block decodes three words from it.
- `TIMEOUT_CYCLES`, default `1000`, number of cycles allowed in RUN before the watchdog fires.
- `BLINK_LOG2`, default `22`, log2 of the LED blink half-period in cycles.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `addr`  in  32  data-bus byte address (the ALU result).
- `wdata`  in  32  write data (rs2 data).
- `wen`  in  1  data-bus write enable (`DM_wen`).
- `rdata`  out  32  combinational read data for a decoded address; 0 otherwise.
- `sel`  out  1  high when `addr[31:2]` matches one of the block's three words. The top level uses it to steer `rdata` and suppress data-memory writes.
- `done`  out  1  state is PASS, FAIL or TIMEOUT.
- `pass`  out  1  state is PASS.
- `fail`  out  1  state is FAIL or TIMEOUT.
- `fail_num`  out  31  test number taken from the failing write; 0 unless in FAIL.
- `leds`  out  6  LED pattern, active-high.

## Operation
- Address decode compares `addr[31:2]` only; `addr[1:0]` is ignored. Writes are full-word.
  - `TOHOST_ADDR+0`: TOHOST, write-only; reads return 0.
  - `TOHOST_ADDR+4`: STATUS, read-only: `{fail_num[29:0], state[1:0]}`.
  - `TOHOST_ADDR+8`: CYCLE, read-only: cycle counter.
- State encoding: RUN=0, PASS=1, FAIL=2, TIMEOUT=3. Reset state is RUN.
- In RUN, a TOHOST write with `wdata[0]=1` is a result:
  - `wdata==1` → PASS.
  - Any other odd value → FAIL, with `fail_num <= wdata[31:1]`.
- In RUN, a TOHOST write with `wdata[0]=0` is ignored. This includes 0.
- Terminal states (PASS, FAIL, TIMEOUT) are sticky until `rst`. All writes are ignored there.
- Writes to STATUS or CYCLE are ignored. `sel` is still asserted for them.
- Cycle counter: 32-bit, increments every cycle in RUN, and freezes once the state leaves RUN.
- Watchdog: in RUN, when `cycle == TIMEOUT_CYCLES-1` and no valid result write occurs that cycle, the next state is TIMEOUT.
- Simultaneous watchdog expiry and valid result write: the write wins.
- LEDs:
  - RUN: `leds = 6'b000001` with bit 0 toggling every 2^`BLINK_LOG2` cycles.
  - PASS: `6'b111111`.
  - FAIL: `{blink, fail_num[4:0]}`.
  - TIMEOUT: alternates between `101010` and `010101` at the blink rate.
- The blink counter is a separate free-running `BLINK_LOG2`-bit counter, cleared by `rst`.

## Timing
- Reset values: state=RUN, cycle=0, blink counter=0, `fail_num=0`, `done=0`, `pass=0`, `fail=0`, `leds=6'b000001`.
- `rdata` and `sel` are combinational, with zero-cycle latency, matching data-memory read timing.
- Result latency: a write sampled at edge N is visible on `done`, `pass`, `fail`, `fail_num` and `leds` after edge N.
- A read of STATUS in the cycle after the write returns the new state.
- After reset the first edge makes cycle=1. TIMEOUT is entered at edge number `TIMEOUT_CYCLES`.
- `rst` asserted in any state, including mid-FAIL, returns every register to its reset value at that edge. Stimulus on `wen` during the `rst` cycle is discarded.

## Configuration
- `TEST_STATUS_WATCHDOG_EN` defined: the watchdog and the TIMEOUT state are present as described.
- Not defined: no watchdog logic is built.
  - RUN persists until a result write arrives.
  - The CYCLE register still counts in RUN and saturates at `32'hFFFF_FFFF`.
  - State value 3 is unreachable.

## Test plan
- Reset, then write `32'h1` to TOHOST at cycle 5 → after the next edge: `pass=1`, `done=1`, `leds=6'b111111`, STATUS reads `32'h1`, CYCLE frozen at 6.
- Write `32'h7` → FAIL with `fail_num=3`, `leds[4:0]=5'b00011`, STATUS reads `32'hE`. A later write of `32'h1` leaves the state at FAIL.
- Watchdog on, no writes, `TIMEOUT_CYCLES=1000` → `fail=1` and STATUS=3 after edge 1000, not before; CYCLE reads 1000.
- Write `32'h1` on the exact cycle the watchdog expires → PASS, not TIMEOUT.
- Write `32'h0` and `32'h4` to TOHOST, and `32'h1` to STATUS → state stays RUN, `sel` is high for all three, `rdata` reads 0 for TOHOST.
- Enter FAIL, assert `rst` for one cycle → all outputs return to reset values. A subsequent `32'h1` write gives PASS. With the macro undefined, 2000 idle cycles leave the state in RUN.
